// File: rtl/dice_pkg.sv
// dice_pkg: shared state encoding, face limits and face check for the dice turn controller
//   state_t   IDLE/ROLL/SETTLE/REPORT turn phases
//   FACE_W    width of a dice face
//   FACE_MIN  lowest legal face
//   FACE_MAX  highest legal face
//   face_bad  1 when a face lies outside FACE_MIN..FACE_MAX
package dice_pkg;
    typedef enum logic [1:0] {IDLE, ROLL, SETTLE, REPORT} state_t;
    localparam int FACE_W = 3;
    localparam logic [FACE_W-1:0] FACE_MIN = 3'd1;
    localparam logic [FACE_W-1:0] FACE_MAX = 3'd6;
    function automatic logic face_bad(input logic [FACE_W-1:0] v);
        return (v < FACE_MIN) || (v > FACE_MAX);
    endfunction
endpackage

// File: rtl/dice_turn_ctrl_if.sv
// dice_turn_ctrl_if: button, dice-roller and result signals of the dice turn controller
//   req            player button levels          (into controller)
//   dice_throw     registered face from roller   (into controller)
//   dice_button    roll-enable to roller         (from controller)
//   grant          one-hot current owner         (from controller)
//   busy           controller not idle           (from controller)
//   result_*       reported turn outcome         (from controller)
//   master: controller side; slave: board/roller side
interface dice_turn_ctrl_if #(
    parameter int N_PLAYERS = 4
);
    localparam int PW = $clog2(N_PLAYERS);
    logic [N_PLAYERS-1:0]         req;
    logic [dice_pkg::FACE_W-1:0]  dice_throw;
    logic                         dice_button;
    logic [N_PLAYERS-1:0]         grant;
    logic                         busy;
    logic                         result_valid;
    logic [PW-1:0]                result_player;
    logic [dice_pkg::FACE_W-1:0]  result_value;
    logic                         result_err;
    logic                         result_tmo;
    modport master (
        input  req, dice_throw,
        output dice_button, grant, busy, result_valid, result_player,
               result_value, result_err, result_tmo
    );
    modport slave (
        output req, dice_throw,
        input  dice_button, grant, busy, result_valid, result_player,
               result_value, result_err, result_tmo
    );
endinterface

// File: rtl/dice_turn_ctrl_rr_arbiter.sv
// rr_arbiter: picks the first eligible player at or after ptr, wrapping round
//   eligible  in   N_PLAYERS        players that may be granted
//   ptr       in   clog2(N_PLAYERS) highest-priority player index
//   gnt       out  N_PLAYERS        one-hot winner, 0 when none eligible
//   idx       out  clog2(N_PLAYERS) winner index
//   any       out  1                some player eligible
module rr_arbiter #(
    parameter int N_PLAYERS = 4
) (
    input  logic [N_PLAYERS-1:0]         eligible,
    input  logic [$clog2(N_PLAYERS)-1:0] ptr,
    output logic [N_PLAYERS-1:0]         gnt,
    output logic [$clog2(N_PLAYERS)-1:0] idx,
    output logic                         any
);
    localparam int PW = $clog2(N_PLAYERS);
    assign any = |eligible;
    // Scan from the farthest offset down so the nearest eligible player is written last and wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N_PLAYERS - 1; k >= 0; k--) begin
            if (eligible[(int'(ptr) + k) % N_PLAYERS]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % N_PLAYERS] = 1'b1;
                idx = PW'((int'(ptr) + k) % N_PLAYERS);
            end
        end
    end
endmodule

// File: rtl/dice_turn_ctrl.sv
// dice_turn_ctrl: round-robin turn controller sharing one dice roller between player buttons
//   clk   in  clock
//   rst   in  asynchronous active-high reset
//   bus   dice_turn_ctrl_if.master: req/dice_throw in; dice_button, grant, busy, result_* out
//   Optional DICE_BONUS_SIX_EN: a clean 6 gives the same player another roll straight away.
module dice_turn_ctrl
    import dice_pkg::*;
#(
    parameter int N_PLAYERS       = 4,
    parameter int MIN_ROLL_CYCLES = 8,
    parameter int MAX_ROLL_CYCLES = 255
) (
    input logic              clk,
    input logic              rst,
    dice_turn_ctrl_if.master bus
);
    localparam int PW = $clog2(N_PLAYERS);
    localparam int CW = $clog2(MAX_ROLL_CYCLES + 1);

    state_t                state_q, state_d;
    logic [N_PLAYERS-1:0]  armed_q, armed_d;
    logic [N_PLAYERS-1:0]  grant_q, grant_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]         g_idx_q, g_idx_d;
    logic [CW-1:0]         roll_cnt_q, roll_cnt_d;
    logic                  tmo_q, tmo_d;
    logic                  dice_button_q, dice_button_d;
    logic                  busy_q, busy_d;
    logic                  rv_q, rv_d;
    logic [PW-1:0]         rp_q, rp_d;
    logic [FACE_W-1:0]     rval_q, rval_d;
    logic                  rerr_q, rerr_d;
    logic                  rtmo_q, rtmo_d;

    logic [N_PLAYERS-1:0]  eligible, arb_gnt;
    logic [PW-1:0]         arb_idx, g_next;
    logic                  arb_any, min_ok, at_max, rel_exit, roll_done, bonus;

    assign eligible  = bus.req & armed_q;
    assign min_ok    = roll_cnt_q >= CW'(MIN_ROLL_CYCLES);
    assign at_max    = roll_cnt_q == CW'(MAX_ROLL_CYCLES);
    assign rel_exit  = min_ok && !bus.req[g_idx_q];
    assign roll_done = rel_exit || at_max;
    assign g_next    = (g_idx_q == PW'(N_PLAYERS - 1)) ? '0 : g_idx_q + 1'b1;
`ifdef DICE_BONUS_SIX_EN
    assign bonus = (rval_q == FACE_MAX) && !rerr_q && !rtmo_q;
`else
    assign bonus = 1'b0;
`endif

    rr_arbiter #(.N_PLAYERS(N_PLAYERS)) u_arb (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .gnt      (arb_gnt),
        .idx      (arb_idx),
        .any      (arb_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            armed_q       <= '0;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            g_idx_q       <= '0;
            roll_cnt_q    <= '0;
            tmo_q         <= 1'b0;
            dice_button_q <= 1'b0;
            busy_q        <= 1'b0;
            rv_q          <= 1'b0;
            rp_q          <= '0;
            rval_q        <= '0;
            rerr_q        <= 1'b0;
            rtmo_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            g_idx_q       <= g_idx_d;
            roll_cnt_q    <= roll_cnt_d;
            tmo_q         <= tmo_d;
            dice_button_q <= dice_button_d;
            busy_q        <= busy_d;
            rv_q          <= rv_d;
            rp_q          <= rp_d;
            rval_q        <= rval_d;
            rerr_q        <= rerr_d;
            rtmo_q        <= rtmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = arb_any ? ROLL : IDLE;
            ROLL:    state_d = roll_done ? SETTLE : ROLL;
            SETTLE:  state_d = REPORT;
            REPORT:  state_d = bonus ? ROLL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // A released button re-arms its player; the grant below disarms the winner.
        armed_d       = armed_q | ~bus.req;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        g_idx_d       = g_idx_q;
        roll_cnt_d    = roll_cnt_q;
        tmo_d         = tmo_q;
        rv_d          = 1'b0;
        rp_d          = rp_q;
        rval_d        = rval_q;
        rerr_d        = rerr_q;
        rtmo_d        = rtmo_q;
        dice_button_d = state_d == ROLL;
        busy_d        = state_d != IDLE;
        case (state_q)
            IDLE: if (arb_any) begin
                grant_d    = arb_gnt;
                g_idx_d    = arb_idx;
                armed_d    = (armed_q | ~bus.req) & ~arb_gnt;
                roll_cnt_d = CW'(1);
                tmo_d      = 1'b0;
            end
            ROLL: begin
                roll_cnt_d = (roll_done || at_max) ? roll_cnt_q : roll_cnt_q + 1'b1;
                tmo_d      = roll_done ? !rel_exit : tmo_q;
            end
            SETTLE: begin
                rv_d   = 1'b1;
                rp_d   = g_idx_q;
                rval_d = bus.dice_throw;
                rerr_d = face_bad(bus.dice_throw);
                rtmo_d = tmo_q;
            end
            REPORT: if (bonus) begin
                roll_cnt_d = CW'(1);
                tmo_d      = 1'b0;
            end else begin
                grant_d  = '0;
                rr_ptr_d = g_next;
            end
            default: ;
        endcase
    end

    assign bus.dice_button   = dice_button_q;
    assign bus.grant         = grant_q;
    assign bus.busy          = busy_q;
    assign bus.result_valid  = rv_q;
    assign bus.result_player = rp_q;
    assign bus.result_value  = rval_q;
    assign bus.result_err    = rerr_q;
    assign bus.result_tmo    = rtmo_q;
endmodule

// File: tb/tb_dice_turn_ctrl.sv
// tb_dice_turn_ctrl: table, hand-written and random turns against a turn-level reference model
module tb_dice_turn_ctrl;
    localparam int N = 4, MINC = 8, MAXC = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force7 = 1'b0;
    logic [2:0] face;
    always #5 clk = ~clk;

    dice_turn_ctrl_if #(.N_PLAYERS(N)) bus();
    dice_turn_ctrl #(.N_PLAYERS(N), .MIN_ROLL_CYCLES(MINC), .MAX_ROLL_CYCLES(MAXC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Dice roller: face steps 1..6 on every clock while the roll-enable is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) face <= 3'd1;
        else if (bus.dice_button) face <= (face == 3'd6) ? 3'd1 : face + 3'd1;
    end
    assign bus.dice_throw = force7 ? 3'd7 : face;

    int errors = 0, checks = 0;
    int model_ptr = 0, mf = 1;

    typedef struct {
        logic [3:0] mask;
        int         hold;
        bit         f7;
        int         ep;
        int         el;
        bit         et;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] m, input int ptr);
        for (int k = 0; k < N; k++) if (m[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic int roll_len(input int h);
        return h < MINC ? MINC : (h > MAXC ? MAXC : h);
    endfunction

    function automatic int adv(input int f, input int l);
        return (f - 1 + l) % 6 + 1;
    endfunction

    // One whole turn starting from IDLE with all players armed; req[ep] is held for `hold` clock edges.
    task automatic run_turn(input logic [3:0] mask, input int hold, input bit f7,
                            input int ep, input int el, input bit et);
        int cyc, btn;
        bit got;
        force7 = f7;
        bus.req = mask;
        cyc = 0; btn = 0; got = 0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.dice_button) btn++;
            if (cyc == 1) begin
                chk("grant_onehot", int'(bus.grant), 1 << ep);
                chk("busy_in_roll", int'(bus.busy), 1);
            end
            if (bus.result_valid) begin
                got = 1;
                mf = adv(mf, el);
                chk("button_cycles", btn, el);
                chk("result_player", int'(bus.result_player), ep);
                chk("result_value", int'(bus.result_value), f7 ? 7 : mf);
                chk("result_err", int'(bus.result_err), int'(f7));
                chk("result_tmo", int'(bus.result_tmo), int'(et));
                model_ptr = (ep + 1) % N;
                bus.req = '0;
            end else begin
                bus.req = 4'($urandom);
                bus.req[ep] = (cyc < hold);
            end
        end
        if (!got) chk("result_timeout", 0, 1);
        @(negedge clk);
        chk("valid_pulse_end", int'(bus.result_valid), 0);
        chk("grant_cleared", int'(bus.grant), 0);
        chk("busy_idle", int'(bus.busy), 0);
        @(negedge clk);
        force7 = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, btn, g;
        bit got;
        logic [3:0] m;
        int h;
        bit f;
        for (int i = 0; i < 5; i++) tbl[i] = '{4'b1111, 10, 1'b0, i % 4, 10, 1'b0};
        tbl[5]  = '{4'b0100, 20,  1'b0, 2, 20,  1'b0};
        tbl[6]  = '{4'b0001, 2,   1'b0, 0, 8,   1'b0};
        tbl[7]  = '{4'b0010, 300, 1'b0, 1, 255, 1'b1};
        tbl[8]  = '{4'b1000, 12,  1'b1, 3, 12,  1'b0};
        tbl[9]  = '{4'b0010, 8,   1'b0, 1, 8,   1'b0};
        tbl[10] = '{4'b1001, 9,   1'b0, 3, 9,   1'b0};
        tbl[11] = '{4'b0001, 255, 1'b0, 0, 255, 1'b0};

        bus.req = '0;
        repeat (2) @(negedge clk);
        chk("rst_button", int'(bus.dice_button), 0);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.result_valid), 0);
        chk("rst_player", int'(bus.result_player), 0);
        chk("rst_value", int'(bus.result_value), 0);
        chk("rst_err", int'(bus.result_err), 0);
        chk("rst_tmo", int'(bus.result_tmo), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++)
            run_turn(tbl[i].mask, tbl[i].hold, tbl[i].f7, tbl[i].ep, tbl[i].el, tbl[i].et);

        // Timeout with the button still held afterwards: no re-grant until released.
        bus.req = 4'b0010;
        cyc = 0; btn = 0; got = 0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.dice_button) btn++;
            if (bus.result_valid) begin
                got = 1;
                mf = adv(mf, MAXC);
                chk("held_tmo_player", int'(bus.result_player), pick(4'b0010, model_ptr));
                chk("held_tmo_flag", int'(bus.result_tmo), 1);
                chk("held_tmo_cycles", btn, MAXC);
                chk("held_tmo_value", int'(bus.result_value), mf);
                model_ptr = 2;
            end
        end
        if (!got) chk("held_tmo_timeout", 0, 1);
        g = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.grant != '0) g++;
        end
        chk("held_no_regrant", g, 0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        run_turn(4'b0010, 10, 1'b0, pick(4'b0010, model_ptr), 10, 1'b0);

        for (int i = 0; i < 20; i++) begin
            m = 4'($urandom_range(1, 15));
            h = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 262)) : int'($urandom_range(1, 30));
            f = ($urandom_range(0, 7) == 0);
            run_turn(m, h, f, pick(m, model_ptr), roll_len(h), h > MAXC);
        end

        // Reset in the middle of a roll, button kept held through and after it.
        bus.req = 4'b0100;
        repeat (5) @(negedge clk);
        chk("pre_rst_button", int'(bus.dice_button), 1);
        rst = 1'b1;
        #1;
        chk("midrst_button", int'(bus.dice_button), 0);
        chk("midrst_grant", int'(bus.grant), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        mf = 1;
        g = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.grant != '0) g++;
        end
        chk("held_after_rst", g, 0);
        bus.req = '0;
        repeat (2) @(negedge clk);
        run_turn(4'b0100, 10, 1'b0, 2, 10, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
